// File: rtl/fnn_pkg.sv
// -----------------------------------------------------------------------------
// fnn_pkg
//   Shared definitions for the fully connected network accelerator.
//
//   Contents:
//     ser_state_t - state encoding of the inter-layer serializer
//                   (IDLE: waiting for a complete vector, SHIFT: replaying it)
//     DATA_WIDTH  - default activation width, reused by the neuron and
//                   serializer instances so every layer agrees on it
// -----------------------------------------------------------------------------
package fnn_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    localparam int DATA_WIDTH = 16;

endpackage : fnn_pkg

// File: rtl/layer_out_serializer.sv
// -----------------------------------------------------------------------------
// layer_out_serializer
//   Collects the parallel activations of one layer (each neuron reports with
//   its own output-valid pulse, in any order and at any time) and, once every
//   neuron has reported, replays the vector one value per cycle in neuron
//   index order as the serial input stream of the next layer.
//
//   Two banks make this double buffered:
//     capture bank - hold[i] + pending[i], filled by the neuron_valid pulses
//     shift bank   - shreg[i], loaded from hold in one cycle, then read out
//   so the next vector can be collected while the current one is shifting.
//
//   Ports:
//     clk          clock
//     rst          synchronous, active-high reset
//     neuron_out   activations, slice [i*dataWidth +: dataWidth] is neuron i
//     neuron_valid per-neuron output-valid pulse, bit i qualifies slice i
//     out_data     serial activation, forced to 0 while out_valid is low
//     out_valid    out_data carries an element this cycle
//     out_last     element numNeurons-1 (only together with out_valid)
//     busy         high while the shifter is replaying a vector
//     overrun      sticky: a neuron reported twice for the same vector
//
//   Stream protocol: out_valid is a pure valid with no ready. Once a vector
//   starts, numNeurons elements follow on consecutive cycles and the consumer
//   must take one element on every cycle in which out_valid is high.
//
//   All outputs come straight from flops; nothing combinational reaches them
//   from the inputs.
// -----------------------------------------------------------------------------
module layer_out_serializer
    import fnn_pkg::*;
#(
    parameter int numNeurons = 30,
    parameter int dataWidth  = DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [numNeurons*dataWidth-1:0]  neuron_out,
    input  logic [numNeurons-1:0]            neuron_valid,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    output logic                             out_last,
    output logic                             busy,
    output logic                             overrun
);

    localparam int IDX_W = $clog2(numNeurons);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(numNeurons - 1);

    // Serializer state; busy is the externally visible copy of (state == SHIFT).
    ser_state_t                  state;
    logic [IDX_W-1:0]            idx;
    logic [IDX_W-1:0]            idx_next;

    logic [numNeurons-1:0]       pending;
    logic [numNeurons-1:0]       pending_next;
    logic [numNeurons-1:0]       accept;
    logic [numNeurons-1:0]       drop;
    logic                        load;

    logic [dataWidth-1:0]        hold_arr  [numNeurons];
    logic [dataWidth-1:0]        shreg_arr [numNeurons];

    // A complete vector is handed to the shifter only from IDLE.
    assign load = (state == IDLE) && (&pending);

    // A pulse is accepted if its slot is free, or if the slot is being freed
    // by the load on this very edge: the new value then starts the next vector.
    // Only a pulse that finds its slot still owned by the current vector is
    // dropped.
    assign accept = neuron_valid & (~pending | {numNeurons{load}});
    assign drop   = neuron_valid & pending & {numNeurons{~load}};

    assign pending_next = (load ? '0 : pending) | accept;

    assign idx_next = idx + 1'b1;

    // -------------------------------------------------------------------------
    // Capture and shift banks, one slot per neuron. Data registers carry no
    // reset: pending and state decide whether their contents mean anything.
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < numNeurons; i++) begin : g_bank
        logic [dataWidth-1:0] hold_r;
        logic [dataWidth-1:0] shreg_r;

        always_ff @(posedge clk) begin
            if (accept[i]) begin
                hold_r <= neuron_out[i*dataWidth +: dataWidth];
            end
            // Takes the value held before this edge, so a colliding capture
            // on the load edge does not leak into the vector being loaded.
            if (load) begin
                shreg_r <= hold_r;
            end
        end

        assign hold_arr[i]  = hold_r;
        assign shreg_arr[i] = shreg_r;
    end

    // -------------------------------------------------------------------------
    // Control: pending vector, sticky overrun, and the IDLE/SHIFT machine with
    // registered stream outputs. out_* always describe the element on the wire
    // in the current cycle, so each edge computes the element of the next one.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            pending   <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            pending <= pending_next;

            if (|drop) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (load) begin
                        // shreg is written on this same edge, so element 0
                        // comes straight from hold to keep the 2-cycle latency.
                        state     <= SHIFT;
                        idx       <= '0;
                        out_valid <= 1'b1;
                        out_data  <= hold_arr[0];
                        out_last  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                SHIFT: begin
                    if (idx == LAST_IDX) begin
                        state     <= IDLE;
                        idx       <= '0;
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        idx       <= idx_next;
                        out_data  <= shreg_arr[idx_next];
                        out_last  <= (idx_next == LAST_IDX);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : layer_out_serializer

// File: doc/layer_out_serializer.md
# layer_out_serializer

Inter-layer serializer for the fully connected network accelerator. It captures the parallel activation outputs of one layer's neurons as each neuron's output-valid pulse arrives. It then replays them, one value per cycle in neuron-index order, as the serial input stream (data plus valid) that every neuron of the next layer consumes. The block is double buffered, so the next layer's results can be collected while the current vector is still being shifted out.

## Interface
Parameters:
- numNeurons, 30, neurons in the producing layer (≥2); also the output vector length.
- dataWidth, 16, width of one activation value.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high. Clock is clk.
- neuron_out  in  numNeurons*dataWidth  activations; slice [i*dataWidth +: dataWidth] belongs to neuron i.
- neuron_valid  in  numNeurons  per-neuron output-valid pulse; bit i qualifies slice i.
- out_data  out  dataWidth  serial activation to the next layer; 0 whenever out_valid is low.
- out_valid  out  1  out_data is valid; drives the next layer's input-valid.
- out_last  out  1  high together with out_valid on the final element (neuron numNeurons-1).
- busy  out  1  high in state SHIFT.
- overrun  out  1  sticky error flag; cleared only by rst.

## Operation
- Capture bank: hold[numNeurons] registers plus a pending[numNeurons] bit vector.
  - On neuron_valid[i] with pending[i]=0: hold[i] <= slice i and pending[i] <= 1.
  - On neuron_valid[i] with pending[i]=1: the new value is dropped, hold[i] is kept, and overrun <= 1.
- Capture operates in every state, independent of the shifter.
- Shift bank: shreg[numNeurons] plus an index counter idx of width $clog2(numNeurons).
- State machine:
  - IDLE: if pending is all ones, then shreg <= hold, pending <= 0, idx <= 0, and go to SHIFT.
  - SHIFT: out_valid=1 and out_data=shreg[idx]. Increment idx each cycle. When idx==numNeurons-1, assert out_last and go to IDLE; idx wraps to 0.
- Load and capture in the same cycle: if the load edge coincides with neuron_valid[i], the cleared pending[i] is overridden. pending[i] <= 1 and hold[i] takes the new value, so it belongs to the next vector. The loaded shreg[i] takes the old hold[i].
- There is no back-pressure. The downstream layer must accept one value per cycle while out_valid is high.
- Reset is honoured in any state, including mid-SHIFT. The remaining elements are discarded and no partial out_last is produced.
- Reset values: state IDLE, pending 0, idx 0, out_valid 0, out_last 0, out_data 0, busy 0, overrun 0. Hold and shift data need no reset.

## Timing
- Let C be the cycle in which the last outstanding neuron_valid bit is high.
  - C+1: pending is full in IDLE; shreg is loaded at the end of C+1.
  - C+2 .. C+numNeurons+1: out_valid=1, out_data = neuron 0 .. numNeurons-1.
  - out_last is high only in C+numNeurons+1.
- Latency from the last capture to the first output: 2 cycles.
- Back-to-back vectors: if the next vector completes during SHIFT, one bubble cycle (IDLE load) follows out_last. The next vector's first element appears 2 cycles after the previous out_last.
- Neurons may complete in any order or cycle; only the full pending vector triggers the load.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package fnn_pkg:
  - state typedef ser_state_t {IDLE, SHIFT};
  - default DATA_WIDTH = 16 constant, reused by the neuron and serializer instances.
- Single module, with no sub-module. The capture bank and shift bank are generate loops over numNeurons inside layer_out_serializer.

## Test plan
- Simultaneous completion: numNeurons=4, all valid bits high in cycle 10 with values 0x0001..0x0004. Required: out_valid in cycles 12-15 with data 1,2,3,4; out_last only in cycle 15; busy in cycles 12-15.
- Staggered completion: valid bits arrive in order 3,0,2,1 in cycles 5,7,8,20. Required: no output before cycle 22; cycles 22-25 carry neurons 0..3 in index order.
- Double buffering: second vector 0x0A..0x0D fully captured in cycle 13 while the first vector is shifting. Required: first vector in cycles 12-15, bubble in cycle 16, second vector in cycles 17-20, overrun stays 0.
- Overrun: pulse neuron_valid[2] twice before the vector completes (values 0x55 then 0x77). Required: overrun=1 and held; element 2 outputs 0x55; other outputs unaffected.
- Load/capture collision: neuron_valid[1]=1 on the IDLE load edge. Required: current vector keeps the old hold[1]; the new value appears as element 1 of the next vector.
- Mid-shift reset: assert rst during the 2nd output cycle. Required: the next cycle has out_valid=0, out_last=0, overrun=0, busy=0; a subsequent full capture replays correctly starting from element 0.
